// File: rtl/uart_rx_fsm.sv
// UART receiver frame sequencer: start/data/parity/stop sequencing at 8x oversampling.
// Optional saturating error counter enabled by defining UART_RX_ERR_CNT_EN.
module uart_rx_fsm #(
  parameter int DATA_WIDTH = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  input  logic [2:0] edge_cnt,
  input  logic [3:0] bit_cnt,
  input  logic       sampled_bit,
  output logic       cnt_enable,
  output logic       sample_en,
  output logic       deser_en,
  output logic       data_valid,
  output logic       par_err,
  output logic       stp_err,
  output logic       busy,
  output logic [2:0] state_dbg
`ifdef UART_RX_ERR_CNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH);

  state_t state, next_state;
  logic   acc;
  logic   par_en_q;
  logic   par_typ_q;
  logic   bend;
  logic   start_det;
  logic   glitch;

  assign cnt_enable = (state == START) || (state == DATA) ||
                      (state == PARITY) || (state == STOP);
  assign sample_en  = cnt_enable;
  assign busy       = cnt_enable;
  assign bend       = cnt_enable && (edge_cnt == 3'd7);
  assign state_dbg  = state;

  always_comb begin
    next_state = state;
    deser_en   = 1'b0;
    data_valid = 1'b0;
    start_det  = 1'b0;
    glitch     = 1'b0;
    case (state)
      IDLE: begin
        if (!RX_IN) begin
          next_state = START;
          start_det  = 1'b1;
        end
      end
      START: begin
        if (bend) begin
          if (sampled_bit) begin
            next_state = IDLE;
            glitch     = 1'b1;
          end else begin
            next_state = DATA;
          end
        end
      end
      DATA: begin
        if (bend) begin
          deser_en = 1'b1;
          if (bit_cnt == LAST_BIT) next_state = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: if (bend) next_state = STOP;
      STOP:   if (bend) next_state = DONE;
      DONE: begin
        data_valid = ~par_err & ~stp_err;
        // A low line in DONE is already the next frame's start bit.
        if (!RX_IN) begin
          next_state = START;
          start_det  = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      acc       <= 1'b0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_err   <= 1'b0;
      stp_err   <= 1'b0;
    end else begin
      state <= next_state;
      if (start_det) begin
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        acc       <= 1'b0;
        par_err   <= 1'b0;
        stp_err   <= 1'b0;
      end
      if (state == DATA && bend)   acc     <= acc ^ sampled_bit;
      if (state == PARITY && bend) par_err <= (sampled_bit != (acc ^ par_typ_q));
      if (state == STOP && bend)   stp_err <= ~sampled_bit;
    end
  end

`ifdef UART_RX_ERR_CNT_EN
  logic err_event;
  assign err_event = ((state == DONE) && (par_err | stp_err)) || glitch;

  always_ff @(posedge CLK) begin
    if (RST) begin
      err_cnt <= 8'd0;
    end else if (err_event && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: models the edge counter and sampler, drives per-cycle RX waveforms,
// and checks frame timing, flags, deserializer strobes and back-to-back/glitch/reset cases.
module tb_uart_rx_fsm;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [2:0] edge_cnt = 3'd0;
  logic [3:0] bit_cnt = 4'd0;
  logic       sampled_bit = 1'b1;
  logic       cnt_enable, sample_en, deser_en, data_valid, par_err, stp_err, busy;
  logic [2:0] state_dbg;
`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  uart_rx_fsm #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .sampled_bit(sampled_bit),
    .cnt_enable(cnt_enable), .sample_en(sample_en), .deser_en(deser_en),
    .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err), .busy(busy),
    .state_dbg(state_dbg)
`ifdef UART_RX_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // edge/bit counter and mid-bit sampler models
  always @(posedge CLK) begin
    if (RST || !cnt_enable) begin
      edge_cnt <= 3'd0;
      bit_cnt  <= 4'd0;
    end else begin
      edge_cnt <= edge_cnt + 3'd1;
      if (edge_cnt == 3'd7) bit_cnt <= bit_cnt + 4'd1;
    end
  end

  always @(posedge CLK) begin
    if (cnt_enable && edge_cnt == 3'd4) sampled_bit <= RX_IN;
  end

  typedef struct {
    logic       pen;
    logic       ptyp;
    logic [7:0] data;
    logic       pbit;
    logic       sbit;
    logic       exp_dv;
    logic       exp_pe;
    logic       exp_se;
    int         exp_done;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  int   exp_err_cnt = 0;
  logic wave[$];
  int   done_q[$];
  int   dv_q[$];
  logic pe_q[$];
  logic se_q[$];
  int   n_deser, deser_first, deser_last;
  logic [15:0] cap16;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard helpers: waveform construction
  task automatic add_frame(input logic [7:0] d, input logic pen, input logic pbit,
                           input logic sbit, input int start_len);
    for (int i = 0; i < start_len; i++) wave.push_back(1'b0);
    for (int b = 0; b < 8; b++)
      for (int i = 0; i < 8; i++) wave.push_back(d[b]);
    if (pen)
      for (int i = 0; i < 8; i++) wave.push_back(pbit);
    for (int i = 0; i < 8; i++) wave.push_back(sbit);
  endtask

  // driver + monitor: wave[c] is the RX level seen by the posedge ending cycle c
  task automatic run(input int ncyc, input int rst_cyc, input logic flip_cfg);
    logic prev_busy;
    done_q.delete(); dv_q.delete(); pe_q.delete(); se_q.delete();
    n_deser = 0; deser_first = -1; deser_last = -1; cap16 = 16'h0;
    prev_busy = 1'b0;
    @(negedge CLK);
    RX_IN = wave[0];
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (c == 1) begin
        chk("flags_clear_at_start", {par_err, stp_err}, 2'b00);
        chk("active_decode", {cnt_enable, sample_en, busy}, 3'b111);
      end
      if (rst_cyc > 0 && c == rst_cyc + 1) begin
        chk("rst_state", {29'd0, state_dbg}, 32'd0);
        chk("rst_outputs", {cnt_enable, busy, data_valid}, 3'b000);
      end
      if (deser_en) begin
        n_deser++;
        if (deser_first < 0) deser_first = c;
        deser_last = c;
        cap16 = {sampled_bit, cap16[15:1]};
      end
      if (data_valid) dv_q.push_back(c);
      if (prev_busy && !busy) begin
        done_q.push_back(c);
        pe_q.push_back(par_err);
        se_q.push_back(stp_err);
      end
      prev_busy = busy;
      RX_IN = (c < wave.size()) ? wave[c] : 1'b1;
      RST = (rst_cyc > 0 && c == rst_cyc);
      if (flip_cfg && c == 20) begin
        PAR_EN  = ~PAR_EN;
        PAR_TYP = ~PAR_TYP;
      end
    end
  endtask

  task automatic check_frame(input vec_t v, input int idx);
    string s;
    s = $sformatf("v%0d", idx);
    chk({s, "_done_count"}, done_q.size(), 1);
    chk({s, "_done_cycle"}, (done_q.size() > 0) ? done_q[0] : -1, v.exp_done);
    chk({s, "_dv_count"}, dv_q.size(), {31'd0, v.exp_dv});
    chk({s, "_dv_cycle"}, (dv_q.size() > 0) ? dv_q[0] : v.exp_done,
        v.exp_done);
    chk({s, "_par_err"}, (pe_q.size() > 0) ? pe_q[0] : 1'bx, v.exp_pe);
    chk({s, "_stp_err"}, (se_q.size() > 0) ? se_q[0] : 1'bx, v.exp_se);
    chk({s, "_deser_count"}, n_deser, 8);
    chk({s, "_deser_first"}, deser_first, 16);
    chk({s, "_deser_last"}, deser_last, 72);
    chk({s, "_data"}, cap16[15:8], v.data);
    chk({s, "_flags_hold"}, {par_err, stp_err}, {v.exp_pe, v.exp_se});
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 89};
    vecs[1] = '{1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 89};
    vecs[2] = '{1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 81};
    vecs[3] = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 89};
    vecs[4] = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 81};
    vecs[5] = '{1'b1, 1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 89};
    vecs[6] = '{1'b1, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 89};

    // reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    chk("reset_outputs", {cnt_enable, sample_en, deser_en, data_valid, par_err, stp_err, busy},
        7'b0);
    chk("reset_state", {29'd0, state_dbg}, 32'd0);
    repeat (2) @(negedge CLK);

    // table-driven single frames, config flipped mid-frame
    foreach (vecs[i]) begin
      wave.delete();
      add_frame(vecs[i].data, vecs[i].pen, vecs[i].pbit, vecs[i].sbit, 9);
      PAR_EN = vecs[i].pen;
      PAR_TYP = vecs[i].ptyp;
      run(wave.size() + 6, 0, 1'b1);
      check_frame(vecs[i], i);
      if (vecs[i].exp_pe || vecs[i].exp_se) exp_err_cnt++;
    end

    // back-to-back frames 0x55 then 0xAA, no parity
    wave.delete();
    add_frame(8'h55, 1'b0, 1'b0, 1'b1, 9);
    add_frame(8'hAA, 1'b0, 1'b0, 1'b1, 8);
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    run(wave.size() + 6, 0, 1'b0);
    chk("b2b_dv_count", dv_q.size(), 2);
    chk("b2b_dv0", (dv_q.size() > 0) ? dv_q[0] : -1, 81);
    chk("b2b_dv1", (dv_q.size() > 1) ? dv_q[1] : -1, 162);
    chk("b2b_busy_falls", done_q.size(), 2);
    chk("b2b_deser_count", n_deser, 16);
    chk("b2b_deser_last", deser_last, 153);
    chk("b2b_data", cap16, 16'hAA55);

    // start glitch: line low for two cycles only
    wave.delete();
    wave.push_back(1'b0);
    wave.push_back(1'b0);
    run(16, 0, 1'b0);
    chk("glitch_busy_fall", (done_q.size() > 0) ? done_q[0] : -1, 9);
    chk("glitch_deser", n_deser, 0);
    chk("glitch_dv", dv_q.size(), 0);
    chk("glitch_flags", {par_err, stp_err}, 2'b00);
    exp_err_cnt++;
`ifdef UART_RX_ERR_CNT_EN
    chk("err_cnt_total", {24'd0, err_cnt}, exp_err_cnt);
`endif

    // reset in the middle of DATA, then a good frame
    wave.delete();
    add_frame(8'hA5, 1'b1, 1'b0, 1'b1, 9);
    while (wave.size() > 41) void'(wave.pop_back());
    PAR_EN = 1'b1;
    PAR_TYP = 1'b0;
    run(60, 40, 1'b0);
    chk("rst_no_dv", dv_q.size(), 0);
    chk("rst_busy_fall", (done_q.size() > 0) ? done_q[0] : -1, 41);
    chk("rst_deser_count", n_deser, 4);
`ifdef UART_RX_ERR_CNT_EN
    chk("err_cnt_cleared", {24'd0, err_cnt}, 0);
`endif
    wave.delete();
    add_frame(vecs[0].data, vecs[0].pen, vecs[0].pbit, vecs[0].sbit, 9);
    PAR_EN = vecs[0].pen;
    PAR_TYP = vecs[0].ptyp;
    run(wave.size() + 6, 0, 1'b0);
    check_frame(vecs[0], 100);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
- Frame-sequencing controller for the UART receiver. Runs at the 8x oversampling clock.
- Enables and clears the edge/bit counter pair (3-bit edge count, 4-bit bit count), strobes the deserializer, and accumulates and checks parity.
- Checks start and stop bits; issues a one-cycle data_valid per good frame.
- Sits between the RX pin, the data sampler, the edge counter and the deserializer.

Parameters:
- DATA_WIDTH, 8, data bits per frame; legal range 5..8.

Ports:
- CLK  input  1  oversampling clock (8 edges per bit)
- RST  input  1  synchronous reset, active-high
- RX_IN  input  1  raw serial line, idle high
- PAR_EN  input  1  1 = frame carries a parity bit
- PAR_TYP  input  1  0 = even parity, 1 = odd parity
- edge_cnt  input  3  edge count within the current bit, from the edge counter
- bit_cnt  input  4  bit index within the frame (0 = start bit), from the edge counter
- sampled_bit  input  1  majority-voted bit from the sampler; stable when edge_cnt==7
- cnt_enable  output  1  edge counter enable; 0 clears both counts
- sample_en  output  1  data sampler enable
- deser_en  output  1  one-cycle shift strobe to the deserializer
- data_valid  output  1  one-cycle pulse; frame received with no errors
- par_err  output  1  parity error flag for the last frame
- stp_err  output  1  stop-bit error flag for the last frame
- busy  output  1  frame in progress

Behaviour:
- Reset (synchronous, RST=1 at posedge): state=IDLE, parity accumulator=0, latched config=0, all outputs 0 from the next cycle. Reset mid-frame aborts the frame; no data_valid is issued.
- States: IDLE, START, DATA, PARITY, STOP, DONE.
- Bit end (bend) = cnt_enable && edge_cnt==7.
- cnt_enable, sample_en and busy are decoded from state: 1 in START, DATA, PARITY and STOP; 0 in IDLE and DONE.
- IDLE:
  - On RX_IN==0, go to START.
  - Latch PAR_EN and PAR_TYP, clear par_err, stp_err and the accumulator.
  - PAR_EN and PAR_TYP changes mid-frame are ignored.
- START (bit_cnt==0), at bend:
  - sampled_bit==1: false start (glitch), go to IDLE; no flags set.
  - sampled_bit==0: go to DATA.
- DATA, at bend:
  - deser_en=1 for that cycle.
  - acc <= acc ^ sampled_bit.
  - If bit_cnt==DATA_WIDTH, go to PARITY when latched PAR_EN=1, else STOP.
- PARITY, at bend:
  - par_err <= (sampled_bit != (acc ^ latched PAR_TYP)).
  - Go to STOP.
- STOP, at bend:
  - stp_err <= ~sampled_bit.
  - Go to DONE.
- DONE (exactly 1 cycle):
  - data_valid = ~par_err & ~stp_err.
  - If RX_IN==0, go to START (back-to-back frame, latch new config); else go to IDLE.
- Flags: par_err and stp_err hold their value until the next start detection.
- Latency (from the posedge that detects the start, cycle 0):
  - START occupies cycles 1..8.
  - Data bit k (k=1..DATA_WIDTH) has its deser_en at cycle 8+8k.
  - DONE occurs at cycle 8*(DATA_WIDTH+2+PAR_EN)+1.
- No parity state is entered when PAR_EN=0; bit_cnt never exceeds DATA_WIDTH+2.

Optional Feature:
- Macro: UART_RX_ERR_CNT_EN.
- When defined:
  - Adds output err_cnt [7:0].
  - err_cnt increments by 1 in DONE when par_err|stp_err, and on each START->IDLE glitch abort.
  - Saturates at 255; cleared only by RST.
  - When both a DONE error and a glitch could apply, only one increment per cycle.
- When undefined: no port and no register; all other behaviour is identical.

Test Plan:
- PAR_EN=1, PAR_TYP=0, frame 0xA5 LSB-first with parity 0 and stop 1 -> deser_en pulses at cycles 16,24,...,72; DONE at cycle 89; data_valid=1; par_err=0; stp_err=0.
- Same frame with parity bit=1 -> par_err=1, data_valid=0 at cycle 89; par_err holds until the next start.
- PAR_EN=0, frame 0x3C with stop bit=0 -> DONE at cycle 81, stp_err=1, data_valid=0.
- RX_IN low for 2 cycles then high (glitch) -> START->IDLE at cycle 8, zero deser_en pulses, flags 0; with UART_RX_ERR_CNT_EN, err_cnt=1.
- Two back-to-back frames 0x55 and 0xAA, second start bit immediately after the stop bit -> DONE->START directly, two data_valid pulses, 8 deser_en pulses each.
- RST=1 asserted at cycle 40 mid-DATA -> next cycle state=IDLE, cnt_enable=0, no data_valid; a following good frame is received correctly.
